// File: rtl/seg7_scan_display.sv
// Multi-digit time-multiplexed 7-segment driver. A sequential shift-add-3
// converter turns the binary input into BCD, and a prescaled scan walks the digits.
module seg7_scan_display #(
   parameter int NUM_DIGITS   = 4,
   parameter int VALUE_WIDTH  = 14,
   parameter int SCAN_DIV     = 1000,
   parameter int COMMON_ANODE = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [VALUE_WIDTH-1:0] value_in,
   input  logic                   load,
   input  logic                   blank_lz,
   output logic                   busy,
   output logic                   overflow,
   output logic [6:0]             segments,
   output logic [NUM_DIGITS-1:0]  digit_en
);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < n; k++) p = p * 64'd10;
      return p;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    seg_decode = 7'b0111111;
         4'd1:    seg_decode = 7'b0000110;
         4'd2:    seg_decode = 7'b1011011;
         4'd3:    seg_decode = 7'b1001111;
         4'd4:    seg_decode = 7'b1100110;
         4'd5:    seg_decode = 7'b1101101;
         4'd6:    seg_decode = 7'b1111100;
         4'd7:    seg_decode = 7'b0000111;
         4'd8:    seg_decode = 7'b1111111;
         4'd9:    seg_decode = 7'b1100111;
         default: seg_decode = 7'b0000000;
      endcase
   endfunction

   localparam int   BCD_W = 4 * NUM_DIGITS;
   localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int   PRE_W = $clog2(SCAN_DIV);
   localparam int   CNT_W = $clog2(VALUE_WIDTH + 1);
   localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
   localparam logic CA = (COMMON_ANODE != 0);
   localparam logic [NUM_DIGITS-1:0] EN_FIRST = NUM_DIGITS'(1);
   localparam logic [6:0] SEG_DASH = 7'b1000000;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

   state_t                 state, state_nxt;
   logic                   start, shift_en, commit;
   logic [VALUE_WIDTH-1:0] bin_sr;
   logic [BCD_W-1:0]       bcd_sr, bcd_adj, disp_bcd;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   ovf_pend;
   logic [PRE_W-1:0]       presc;
   logic [IDX_W-1:0]       scan_idx;
   logic [3:0]             nib;
   logic                   upper_nz;
   logic [6:0]             seg_nxt;
   logic [NUM_DIGITS-1:0]  en_nxt;
   logic                   unused_bcd_msb;

   // NOTE: every register is written with <= so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: defaults come first so no path through the case leaves a latch.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      shift_en  = 1'b0;
      commit    = 1'b0;
      case (state)
         S_IDLE: begin
            if (load) begin
               start     = 1'b1;
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            if (bit_cnt == CNT_W'(VALUE_WIDTH - 1)) state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            commit    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   // Add-3 correction on every nibble that would become >= 10 after the shift.
   always_comb begin
      bcd_adj = bcd_sr;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd_sr[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
      end
   end

   // Carry out of the top nibble is dropped; the overflow flag covers it.
   assign unused_bcd_msb = bcd_adj[BCD_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sr   <= '0;
         bcd_sr   <= '0;
         bit_cnt  <= '0;
         ovf_pend <= 1'b0;
         disp_bcd <= '0;
         overflow <= 1'b0;
      end else begin
         if (start) begin
            bin_sr   <= value_in;
            bcd_sr   <= '0;
            bit_cnt  <= '0;
            ovf_pend <= (64'(value_in) >= LIMIT);
         end else if (shift_en) begin
            bcd_sr  <= {bcd_adj[BCD_W-2:0], bin_sr[VALUE_WIDTH-1]};
            bin_sr  <= bin_sr << 1;
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (commit) begin
            disp_bcd <= bcd_sr;
            overflow <= ovf_pend;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         scan_idx <= '0;
      end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
         presc    <= '0;
         scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Pick the current nibble and decide whether it is a leading zero.
   always_comb begin
      nib      = 4'd0;
      upper_nz = 1'b0;
      en_nxt   = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (IDX_W'(k) == scan_idx) begin
            nib       = disp_bcd[4*k +: 4];
            en_nxt[k] = 1'b1;
         end
         if ((IDX_W'(k) >= scan_idx) && (disp_bcd[4*k +: 4] != 4'd0)) upper_nz = 1'b1;
      end
      if (overflow)                                        seg_nxt = SEG_DASH;
      else if (blank_lz && (scan_idx != '0) && !upper_nz) seg_nxt = 7'b0000000;
      else                                                 seg_nxt = seg_decode(nib);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments <= {7{CA}};
         digit_en <= EN_FIRST ^ {NUM_DIGITS{CA}};
      end else begin
         segments <= seg_nxt ^ {7{CA}};
         digit_en <= en_nxt ^ {NUM_DIGITS{CA}};
      end
   end

endmodule
